key_conditioner: RTL and testbench

Multi-channel push-button conditioner between the raw board KEY pins and the chip-checker platform's PIO inputs (accumulate, reset-wire, key inputs). Each channel synchronises its raw input, debounces it with a stability counter, and produces a clean level, one-cycle press/release pulses, and optional hold-to-repeat pulses. Software and chip-test logic therefore see exactly one event per physical press.

---
 rtl/key_cond_pkg.sv | 33 +++
 rtl/key_debounce_channel.sv | 135 +++++++++++++
 rtl/key_conditioner.sv | 43 ++++
 tb/tb_key_conditioner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared types and elaboration-time helpers for the key conditioner.
// Contents: per-channel debounce state enum, counter-width helper, parameter legality check.
// No ports; imported by key_debounce_channel and key_conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Bits needed to hold 0..max_val; never less than one bit so a
  // disabled feature still yields a legal vector width.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Debounce needs at least two stable samples; the repeat period must be
  // non-zero so periodic mode always terminates its count.
  function automatic bit params_legal(input int debounce_cycles,
                                      input int repeat_delay,
                                      input int repeat_period);
    return (debounce_cycles >= 2) && (repeat_delay >= 0) && (repeat_period >= 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one push-button channel - 2-flop synchroniser, stability-counter
// debounce FSM and optional hold-to-repeat generator. All outputs registered.
// Ports: clk_i/rst_i (async active-high), raw_i (raw pin), level_o, press_o, release_o, repeat_o.
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

  logic [1:0]    sync_q;
  key_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rcnt_q;
  logic          periodic_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;
  logic          repeat_q;
  logic          s;
  logic [RW-1:0] rcnt_last;

  // Normalised synchronised input: 1 = pressed.
  assign s = sync_q[1] ^ ACTIVE_LOW;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign rcnt_last = periodic_q ? RP_LAST : RD_LAST;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // Synchroniser holds the raw "released" level so a key held through
      // reset is seen as a fresh press once reset drops.
      sync_q     <= {2{ACTIVE_LOW}};
      state_q    <= RELEASED;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      periodic_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;

      case (state_q)
        RELEASED: begin
          if (s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_ONE;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        PRESSED: begin
          if (!s) begin
            state_q    <= RELEASE_WAIT;
            cnt_q      <= CNT_ONE;
            rcnt_q     <= '0;
            periodic_q <= 1'b0;
          end else if (REPEAT_EN) begin
            if (rcnt_q == rcnt_last) begin
              repeat_q   <= 1'b1;
              periodic_q <= 1'b1;
              rcnt_q     <= '0;
            end else begin
              rcnt_q <= rcnt_q + RW'(1);
            end
          end
        end

        RELEASE_WAIT: begin
          // A bounce back to pressed restarts the repeat cadence from the
          // initial delay (rcnt/periodic were cleared on leaving PRESSED).
          if (s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: NUM_KEYS independent debounced push-button channels feeding PIO inputs.
// Ports: clk_clk, reset_reset (async active-high), key_raw[NUM_KEYS] raw pins;
//        key_level / key_press / key_release / key_repeat[NUM_KEYS], all registered.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int ACTIVE_LOW_IN   = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  if (!params_legal(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_param_check
    $fatal(1, "key_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_PERIOD >= 1");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .ACTIVE_LOW      (ACTIVE_LOW_IN != 0)
    ) u_ch (
      .clk_i     (clk_clk),
      .rst_i     (reset_reset),
      .raw_i     (key_raw[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .repeat_o  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random stimulus for key_conditioner,
// checked against a consecutive-sample reference model and explicit edge timings.
// Ports: none (top-level bench).
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam bit AL = 1'b1;

  logic          clk = 1'b0;
  logic          reset_reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS        (NK),
    .ACTIVE_LOW_IN   (1),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: pin samples delayed two edges, then a level flips once
  // DB consecutive samples disagree with it; hold time counts edges spent
  // stably pressed.
  bit h0 [NK];
  bit h1 [NK];
  bit m_lvl [NK];
  bit m_press [NK];
  bit m_rel [NK];
  bit m_rep [NK];
  int m_run [NK];
  int m_hold [NK];

  // Observations of the DUT for timing checks.
  int press_cnt [NK];
  int rel_cnt [NK];
  int last_press [NK];
  int last_rel [NK];
  int rep_q0[$];
  int rep_q2[$];
  int seen_all = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int i = 0; i < NK; i++) begin
      bit s;
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      m_rep[i]   = 1'b0;
      if (reset_reset) begin
        h0[i] = 1'b0; h1[i] = 1'b0; m_lvl[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
      end else begin
        s     = h1[i];
        h1[i] = h0[i];
        h0[i] = key_raw[i] ^ AL;
        if (s != m_lvl[i]) begin
          m_run[i]++;
          m_hold[i] = 0;
          if (m_run[i] == DB) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) m_press[i] = 1'b1;
            else   m_rel[i]   = 1'b1;
          end
        end else if (m_run[i] != 0) begin
          m_run[i]  = 0;
          m_hold[i] = 0;
        end else if (m_lvl[i]) begin
          m_hold[i]++;
          if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RP == 0))
            m_rep[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [NK-1:0] el, ep, er, et;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NK; i++) begin
      el[i] = m_lvl[i]; ep[i] = m_press[i]; er[i] = m_rel[i]; et[i] = m_rep[i];
    end
    check("level",   32'(key_level),   32'(el));
    check("press",   32'(key_press),   32'(ep));
    check("release", 32'(key_release), 32'(er));
    check("repeat",  32'(key_repeat),  32'(et));
    for (int i = 0; i < NK; i++) begin
      if (key_press[i])   begin press_cnt[i]++; last_press[i] = edge_n; end
      if (key_release[i]) begin rel_cnt[i]++;   last_rel[i]   = edge_n; end
    end
    if (key_repeat[0]) rep_q0.push_back(edge_n);
    if (key_repeat[2]) rep_q2.push_back(edge_n);
    if (key_press == 3'b111) seen_all++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int chg, p, n, pc, rc, g, first, rst_left;
    int dur [NK];

    reset_reset = 1'b1;
    key_raw     = 3'b111;
    run(3);
    check("reset_level",   32'(key_level),   32'd0);
    check("reset_press",   32'(key_press),   32'd0);
    check("reset_release", 32'(key_release), 32'd0);
    check("reset_repeat",  32'(key_repeat),  32'd0);
    reset_reset = 1'b0;
    run(8);

    // Clean press on channel 0.
    pc = press_cnt[0];
    key_raw[0] = 1'b0;
    chg = edge_n;
    run(20);
    check("clean_press_count", 32'(press_cnt[0] - pc), 32'd1);
    check("clean_press_edge",  32'(last_press[0]), 32'(chg + 6));
    check("clean_level",       32'(key_level[0]), 32'd1);
    key_raw[0] = 1'b1;
    chg = edge_n;
    run(10);
    check("clean_release_edge", 32'(last_rel[0]), 32'(chg + 6));
    run(4);

    // Bounce on channel 1: never DB stable samples.
    pc = press_cnt[1];
    for (int k = 0; k < 5; k++) begin
      key_raw[1] = 1'b0; run(3);
      key_raw[1] = 1'b1; run(1);
    end
    run(10);
    check("bounce_press_count", 32'(press_cnt[1] - pc), 32'd0);
    check("bounce_level",       32'(key_level[1]), 32'd0);

    // Auto-repeat on channel 2.
    rep_q2.delete();
    rc = rel_cnt[2];
    key_raw[2] = 1'b0;
    chg = edge_n;
    run(36);
    p = chg + 6;
    check("rep_press_edge", 32'(last_press[2]), 32'(p));
    n = 0;
    for (int t = p + RD; t <= chg + 36; t += RP) begin
      first = (rep_q2.size() > n) ? rep_q2[n] : -1;
      check("rep_edge", 32'(first), 32'(t));
      n++;
    end
    check("rep_count", 32'(rep_q2.size()), 32'(n));
    key_raw[2] = 1'b1;
    chg = edge_n;
    run(10);
    check("rep_release_count", 32'(rel_cnt[2] - rc), 32'd1);
    check("rep_release_edge",  32'(last_rel[2]), 32'(chg + 6));
    run(4);

    // Reset while channel 0 is pressed.
    key_raw[0] = 1'b0;
    run(12);
    check("pre_reset_level", 32'(key_level[0]), 32'd1);
    rc = rel_cnt[0];
    reset_reset = 1'b1;
    #1;
    check("async_rst_level",   32'(key_level),   32'd0);
    check("async_rst_press",   32'(key_press),   32'd0);
    check("async_rst_release", 32'(key_release), 32'd0);
    check("async_rst_repeat",  32'(key_repeat),  32'd0);
    run(2);
    reset_reset = 1'b0;
    chg = edge_n;
    pc = press_cnt[0];
    run(12);
    check("post_rst_press_count", 32'(press_cnt[0] - pc), 32'd1);
    check("post_rst_press_edge",  32'(last_press[0]), 32'(chg + 6));
    check("rst_no_release",       32'(rel_cnt[0] - rc), 32'd0);
    key_raw[0] = 1'b1;
    run(12);

    // All channels pressed on the same edge.
    seen_all = 0;
    key_raw = 3'b000;
    chg = edge_n;
    run(10);
    check("simul_seen", 32'(seen_all), 32'd1);
    for (int i = 0; i < NK; i++) check("simul_edge", 32'(last_press[i]), 32'(chg + 6));
    key_raw = 3'b111;
    run(12);

    // Two-cycle release glitch on channel 0 while pressed.
    key_raw[0] = 1'b0;
    run(11);
    rc = rel_cnt[0];
    rep_q0.delete();
    g = edge_n;
    key_raw[0] = 1'b1;
    run(2);
    key_raw[0] = 1'b0;
    run(20);
    first = (rep_q0.size() > 0) ? rep_q0[0] : -1;
    check("glitch_no_release", 32'(rel_cnt[0] - rc), 32'd0);
    check("glitch_level",      32'(key_level[0]), 32'd1);
    check("glitch_rep_edge",   32'(first), 32'(g + 15));
    key_raw[0] = 1'b1;
    run(12);

    // Random bursts with occasional reset pulses.
    rst_left = 0;
    for (int i = 0; i < NK; i++) dur[i] = 1 + int'($urandom_range(0, 6));
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          key_raw[i] = ~key_raw[i];
          dur[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(5, 40));
        end
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset_reset = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        reset_reset = 1'b1;
        rst_left = 2;
      end
      cycle();
    end
    reset_reset = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
